// File: rtl/blowfish128_round_ctrl_if.sv
// blowfish128_round_ctrl_if: block in/out, P-array read port and F-function handshake bundle
// Signals:
//   in_valid/in_ready/in_data/decrypt  block input handshake, in_data = {L,R}, L = [127:64]
//   p_idx/p_key                        combinational P-array read port, p_key = P[p_idx]
//   f_enable/f_x/f_y/f_valid           F-function handshake, f_enable low clears the F-function
//   out_valid/out_ready/out_data       result handshake, out_data = {L,R}
//   busy/err                           status: not idle / sticky F-function timeout
// Modports:
//   master  the round controller
//   slave   the environment (block source, P-array, F-function, result sink)
interface blowfish128_round_ctrl_if #(
    parameter int PIDX_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      in_data;
    logic              decrypt;
    logic [PIDX_W-1:0] p_idx;
    logic [63:0]       p_key;
    logic              f_enable;
    logic [63:0]       f_x;
    logic [63:0]       f_y;
    logic              f_valid;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      out_data;
    logic              busy;
    logic              err;

    modport master (
        input  in_valid, in_data, decrypt, p_key, f_y, f_valid, out_ready,
        output in_ready, p_idx, f_enable, f_x, out_valid, out_data, busy, err
    );

    modport slave (
        output in_valid, in_data, decrypt, p_key, f_y, f_valid, out_ready,
        input  in_ready, p_idx, f_enable, f_x, out_valid, out_data, busy, err
    );
endinterface

// File: rtl/blowfish128_round_ctrl.sv
// blowfish128_round_ctrl: Blowfish-128 Feistel round sequencer driving an external F-function
// Optional feature: define BF128_FFUNC_TIMEOUT_EN to abandon a block when the F-function
// does not answer within TIMEOUT cycles of F_WAIT (sets the sticky err flag).
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous reset, active-high
//   bus     blowfish128_round_ctrl_if.master: block in/out, P-array port, F-function handshake
module blowfish128_round_ctrl #(
    parameter int ROUNDS  = 16,
    parameter int PIDX_W  = 5,
    parameter int TIMEOUT = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    blowfish128_round_ctrl_if.master        bus
);
    if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("ROUNDS must be even and >= 2");
    end
    if ((1 << PIDX_W) < ROUNDS + 2) begin : g_bad_pidx
        $error("PIDX_W too narrow for ROUNDS+2 subkeys");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    localparam logic [PIDX_W-1:0] K_WA   = PIDX_W'(ROUNDS);
    localparam logic [PIDX_W-1:0] K_LAST = PIDX_W'(ROUNDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUND_KEY,
        S_F_WAIT,
        S_MIX,
        S_WHITEN_A,
        S_WHITEN_B,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PIDX_W-1:0] r_rnd;
    logic [PIDX_W-1:0] r_pidx;
    logic [63:0]       r_l;
    logic [63:0]       r_r;
    logic [63:0]       r_fy;
    logic              r_dec;
    logic              r_out_valid;
    logic [127:0]      r_out_data;
    logic [PIDX_W-1:0] w_kidx;
    logic [PIDX_W-1:0] w_pidx;
    logic              w_key_state;
    logic              w_last;
    logic              w_timeout;

    assign w_last      = r_rnd == PIDX_W'(ROUNDS - 1);
    assign w_key_state = r_state == S_ROUND_KEY || r_state == S_WHITEN_A || r_state == S_WHITEN_B;
    assign w_kidx      = r_state == S_WHITEN_A ? K_WA : r_state == S_WHITEN_B ? K_LAST : r_rnd;
    // Decryption walks the P-array backwards: k(i) = ROUNDS+1-i.
    assign w_pidx      = w_key_state ? (r_dec ? K_LAST - w_kidx : w_kidx) : r_pidx;

`ifdef BF128_FFUNC_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    logic [TCNT_W-1:0] r_tcnt;
    logic              r_err;

    // Fires on the TIMEOUT-th F_WAIT cycle that still has no FValid.
    assign w_timeout = r_state == S_F_WAIT && !bus.f_valid && r_tcnt == TCNT_W'(TIMEOUT - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= r_state == S_F_WAIT ? r_tcnt + 1'b1 : '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      w_state_nxt = bus.in_valid ? S_ROUND_KEY : S_IDLE;
            S_ROUND_KEY: w_state_nxt = S_F_WAIT;
            S_F_WAIT:    w_state_nxt = bus.f_valid ? S_MIX : w_timeout ? S_IDLE : S_F_WAIT;
            S_MIX:       w_state_nxt = w_last ? S_WHITEN_A : S_ROUND_KEY;
            S_WHITEN_A:  w_state_nxt = S_WHITEN_B;
            S_WHITEN_B:  w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = r_out_valid && bus.out_ready ? S_IDLE : S_DONE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rnd       <= '0;
            r_pidx      <= '0;
            r_l         <= '0;
            r_r         <= '0;
            r_fy        <= '0;
            r_dec       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_pidx <= w_pidx;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_l   <= bus.in_data[127:64];
                        r_r   <= bus.in_data[63:0];
                        r_dec <= bus.decrypt;
                        r_rnd <= '0;
                    end
                end
                S_ROUND_KEY: r_l <= r_l ^ bus.p_key;
                S_F_WAIT: begin
                    if (bus.f_valid)
                        r_fy <= bus.f_y;
                end
                S_MIX: begin
                    // The last round skips the swap so whitening sees the standard layout.
                    if (w_last) begin
                        r_r <= r_r ^ r_fy;
                    end else begin
                        r_l   <= r_r ^ r_fy;
                        r_r   <= r_l;
                        r_rnd <= r_rnd + 1'b1;
                    end
                end
                S_WHITEN_A: r_r <= r_r ^ bus.p_key;
                S_WHITEN_B: r_l <= r_l ^ bus.p_key;
                S_DONE: begin
                    // Result is registered on the first DONE cycle and held until consumed.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= {r_l, r_r};
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_state == S_IDLE && !i_rst;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.p_idx     = w_pidx;
    assign bus.f_enable  = r_state == S_F_WAIT;
    assign bus.f_x       = r_state == S_F_WAIT ? r_l : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule
